// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, mutually aligned outputs.
// Optional test-pattern source is built when VGA_TIMING_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
`ifdef VGA_TIMING_PATTERN_EN
    input  logic [1:0]    i_mode,
    output logic [1:0]    o_red,
    output logic [1:0]    o_green,
    output logic [1:0]    o_blue,
`endif
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [HW-1:0] o_hpos,
    output logic [VW-1:0] o_vpos,
    output logic          o_sol,
    output logic          o_sof
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_size
        $error("vga_timing_gen: active, porch and sync sizes must be >= 1");
    end

    if (H_ACTIVE % 8 != 0) begin : g_err_h8
        $error("vga_timing_gen: H_ACTIVE must be a multiple of 8");
    end

    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic          sol_c;
    logic          sof_c;

    // Everything below is decoded from the pre-edge counters.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
        end
        de_c  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_c  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        sol_c = (h_cnt == '0);
        sof_c = sol_c && (v_cnt == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            o_hsync <= ~H_SYNC_POL;
            o_vsync <= ~V_SYNC_POL;
            o_de    <= 1'b0;
            o_hpos  <= '0;
            o_vpos  <= '0;
            o_sol   <= 1'b0;
            o_sof   <= 1'b0;
        end else if (i_en) begin
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            o_hsync <= hs_c ? H_SYNC_POL : ~H_SYNC_POL;
            o_vsync <= vs_c ? V_SYNC_POL : ~V_SYNC_POL;
            o_de    <= de_c;
            o_hpos  <= h_cnt;
            o_vpos  <= v_cnt;
            o_sol   <= sol_c;
            o_sof   <= sof_c;
        end
    end

`ifdef VGA_TIMING_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

    logic [1:0]    mode_q;
    logic [1:0]    mode_c;
    logic [SW-1:0] sub_cnt;
    logic [2:0]    bar_cnt;
    logic [2:0]    bar_c;
    logic          chk;
    logic [5:0]    rgb_c;

    // The pixel at (0,0) already uses the mode latched on its own edge.
    always_comb begin
        mode_c = sof_c ? i_mode : mode_q;
        bar_c  = ~bar_cnt;
        chk    = ((32'(h_cnt) ^ 32'(v_cnt)) & 32'd16) != 32'd0;
        rgb_c  = '0;
        if (de_c) begin
            unique case (mode_c)
                2'd0:    rgb_c = 6'h3F;
                2'd1:    rgb_c = {{2{bar_c[2]}}, {2{bar_c[1]}}, {2{bar_c[0]}}};
                2'd2:    rgb_c = chk ? 6'h00 : 6'h3F;
                default: rgb_c = 6'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q  <= '0;
            sub_cnt <= '0;
            bar_cnt <= '0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else if (i_en) begin
            mode_q <= mode_c;
            if (h_wrap) begin
                sub_cnt <= '0;
                bar_cnt <= '0;
            end else if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                bar_cnt <= bar_cnt + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
            {o_red, o_green, o_blue} <= rgb_c;
        end
    end
`endif

endmodule
